// File: rtl/pb_eoc_pkg.sv
// Shared types and constants for the picobello end-of-computation collector.
package pb_eoc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      REPORT = 2'd2
   } eoc_state_e;

   localparam int          EocDoneBit     = 0;
   localparam logic [31:0] EocTimeoutCode = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [30:0] code;
      logic        done;
   } eoc_word_t;

endpackage

// File: rtl/pb_eoc_slot.sv
// One reporting channel: sticky done flag plus the exit code captured with it.
module pb_eoc_slot
   import pb_eoc_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        cap_en_i,
   input  logic        wr_i,
   input  eoc_word_t   word_i,
   output logic        done_o,
   output logic        done_nxt_o,
   output logic [30:0] code_nxt_o
);

   logic        done_q;
   logic [30:0] code_q;
   logic        capture;

   // Only the first report with the done bit set is kept; later writes are ignored.
   assign capture = cap_en_i && wr_i && word_i.done && !done_q;

   always_comb begin
      done_nxt_o = done_q;
      code_nxt_o = code_q;
      if (clr_i) begin
         done_nxt_o = 1'b0;
         code_nxt_o = '0;
      end else if (capture) begin
         done_nxt_o = 1'b1;
         code_nxt_o = word_i.code;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         done_q <= 1'b0;
         code_q <= '0;
      end else begin
         done_q <= done_nxt_o;
         code_q <= code_nxt_o;
      end
   end

   assign done_o = done_q;

endmodule

// File: rtl/pb_eoc_collector.sv
// Aggregates per-channel end-of-computation reports into one verdict behind a valid/ready handshake.
// state  | meaning
// IDLE   | waiting for start_i
// ARMED  | collecting channel reports, timeout counter running
// REPORT | verdict held on the outputs until eoc_ready_i
module pb_eoc_collector
   import pb_eoc_pkg::*;
#(
   parameter int NumChannels  = 4,
   parameter int TimeoutWidth = 32,
   parameter bit FailFast     = 1'b1,
   parameter int IdxWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [NumChannels-1:0]    cfg_mask_i,
   input  logic [TimeoutWidth-1:0]   cfg_timeout_i,
   input  logic [NumChannels-1:0]    ch_valid_i,
   input  logic [NumChannels*32-1:0] ch_data_i,
   output logic [NumChannels-1:0]    ch_done_o,
   output logic                      busy_o,
   output logic                      eoc_valid_o,
   input  logic                      eoc_ready_i,
   output logic [31:0]               exit_code_o,
   output logic [IdxWidth-1:0]       fail_idx_o,
   output logic                      timeout_o
);

   eoc_state_e               state_q, state_d;
   logic [NumChannels-1:0]   mask_q, done_d, cap_en;
   logic [TimeoutWidth-1:0]  timeout_q, cnt_q;
   logic [30:0]              code_d [NumChannels];
   logic                     clr, any_nz, fail, all_done, tmo_hit, finish;
   logic [IdxWidth-1:0]      sel_idx, idx_q;
   logic [30:0]              sel_code;
   logic [31:0]              exit_q;
   logic                     tmo_q;

   assign clr    = (state_q == IDLE) && start_i;
   assign cap_en = (state_q == ARMED && !abort_i) ? mask_q : '0;

   for (genvar g = 0; g < NumChannels; g++) begin : g_slot
      pb_eoc_slot u_slot (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .clr_i      (clr),
         .cap_en_i   (cap_en[g]),
         .wr_i       (ch_valid_i[g]),
         .word_i     (eoc_word_t'(ch_data_i[32*g +: 32])),
         .done_o     (ch_done_o[g]),
         .done_nxt_o (done_d[g]),
         .code_nxt_o (code_d[g])
      );
   end

   // Descending scan so the lowest enabled index with a nonzero code wins.
   always_comb begin
      any_nz   = 1'b0;
      sel_idx  = '0;
      sel_code = '0;
      for (int i = NumChannels - 1; i >= 0; i--) begin
         if (mask_q[i] && (code_d[i] != '0)) begin
            any_nz   = 1'b1;
            sel_idx  = IdxWidth'(i);
            sel_code = code_d[i];
         end
      end
   end

   assign fail     = FailFast && any_nz;
   assign all_done = ((done_d & mask_q) == mask_q);
   assign finish   = fail || all_done;
   assign tmo_hit  = (timeout_q != '0) && (cnt_q == timeout_q - TimeoutWidth'(1)) && !finish;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = (cfg_mask_i == '0) ? REPORT : ARMED;
         end
         ARMED: begin
            if (abort_i)                 state_d = IDLE;
            else if (finish || tmo_hit)  state_d = REPORT;
         end
         REPORT: begin
            if (eoc_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_q == ARMED);
      eoc_valid_o = (state_q == REPORT);
      exit_code_o = exit_q;
      fail_idx_o  = idx_q;
      timeout_o   = tmo_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mask_q    <= '0;
         timeout_q <= '0;
         cnt_q     <= '0;
         exit_q    <= '0;
         idx_q     <= '0;
         tmo_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  mask_q    <= cfg_mask_i;
                  timeout_q <= cfg_timeout_i;
                  cnt_q     <= '0;
                  exit_q    <= '0;
                  idx_q     <= '0;
                  tmo_q     <= 1'b0;
               end
            end
            ARMED: begin
               cnt_q <= cnt_q + TimeoutWidth'(1);
               if (!abort_i) begin
                  if (finish) begin
                     exit_q <= {1'b0, sel_code};
                     idx_q  <= sel_idx;
                     tmo_q  <= 1'b0;
                  end else if (tmo_hit) begin
                     exit_q <= EocTimeoutCode;
                     idx_q  <= '0;
                     tmo_q  <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pb_eoc_collector.sv
// Randomized scoreboard bench for pb_eoc_collector with a behavioural reference model.
module tb_pb_eoc_collector;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         start_i, abort_i, eoc_ready_i;
   logic [3:0]   cfg_mask_i;
   logic [31:0]  cfg_timeout_i;
   logic [3:0]   ch_valid_i;
   logic [127:0] ch_data_i;
   logic [3:0]   ch_done_o;
   logic         busy_o, eoc_valid_o, timeout_o;
   logic [31:0]  exit_code_o;
   logic [1:0]   fail_idx_o;

   pb_eoc_collector dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .abort_i       (abort_i),
      .cfg_mask_i    (cfg_mask_i),
      .cfg_timeout_i (cfg_timeout_i),
      .ch_valid_i    (ch_valid_i),
      .ch_data_i     (ch_data_i),
      .ch_done_o     (ch_done_o),
      .busy_o        (busy_o),
      .eoc_valid_o   (eoc_valid_o),
      .eoc_ready_i   (eoc_ready_i),
      .exit_code_o   (exit_code_o),
      .fail_idx_o    (fail_idx_o),
      .timeout_o     (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] exit_code;
      logic [1:0]  idx;
      logic        tmo;
      int          at_edge;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          edge_cnt = 0;
   logic        prev_v = 1'b0;

   logic [3:0]  sv [64];
   logic [31:0] sd [64][4];
   int          slen;

   always @(posedge clk_i) edge_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected verdict each time valid rises.
   always @(negedge clk_i) begin
      if (!rst_i && eoc_valid_o && !prev_v) begin
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("exit_code", exit_code_o, e.exit_code);
            check("fail_idx", {30'd0, fail_idx_o}, {30'd0, e.idx});
            check("timeout", {31'd0, timeout_o}, {31'd0, e.tmo});
            check("valid_edge", edge_cnt, e.at_edge);
         end
      end
      prev_v = eoc_valid_o;
   end

   task automatic idle_inputs();
      start_i = 0; abort_i = 0; eoc_ready_i = 0;
      ch_valid_i = '0; ch_data_i = '0;
   endtask

   task automatic clear_sched();
      for (int k = 0; k < 64; k++) begin
         sv[k] = '0;
         for (int i = 0; i < 4; i++) sd[k][i] = '0;
      end
      slen = 0;
   endtask

   task automatic sched_wr(input int k, input int ch, input logic [31:0] d);
      sv[k][ch] = 1'b1;
      sd[k][ch] = d;
      if (k + 1 > slen) slen = k + 1;
   endtask

   task automatic run(input logic [3:0] mask, input logic [31:0] tmo);
      logic [3:0]  m_done;
      logic [30:0] m_code [4];
      logic [31:0] w;
      exp_t        e;
      bit          fin;
      int          k, nz, h;
      m_done = '0;
      for (int i = 0; i < 4; i++) m_code[i] = '0;
      fin = 0;
      e = '{exit_code: 32'd0, idx: 2'd0, tmo: 1'b0, at_edge: 0};
      start_i = 1; cfg_mask_i = mask; cfg_timeout_i = tmo;
      if (mask == 4'd0) begin
         e.at_edge = edge_cnt + 1;
         sb_q.push_back(e);
         fin = 1;
      end
      @(posedge clk_i); #1;
      start_i = 0;
      if (!fin) check("busy_rise", {31'd0, busy_o}, 32'd1);
      k = 0;
      while (!fin && k < 400) begin
         ch_valid_i = (k < slen) ? sv[k] : 4'd0;
         for (int i = 0; i < 4; i++) begin
            ch_data_i[32*i +: 32] = (k < slen) ? sd[k][i] : 32'd0;
            w = sd[k < 64 ? k : 0][i];
            if (k < slen && sv[k][i] && mask[i] && w[0] && !m_done[i]) begin
               m_done[i] = 1'b1;
               m_code[i] = w[31:1];
            end
         end
         nz = -1;
         for (int i = 3; i >= 0; i--) if (mask[i] && m_code[i] != 0) nz = i;
         if (nz >= 0 || (m_done & mask) == mask) begin
            e.exit_code = (nz >= 0) ? {1'b0, m_code[nz]} : 32'd0;
            e.idx       = (nz >= 0) ? 2'(nz) : 2'd0;
            e.tmo       = 1'b0;
            e.at_edge   = edge_cnt + 1;
            sb_q.push_back(e);
            fin = 1;
         end else if (tmo != 0 && k == int'(tmo) - 1) begin
            e.exit_code = 32'hFFFF_FFFF;
            e.idx       = 2'd0;
            e.tmo       = 1'b1;
            e.at_edge   = edge_cnt + 1;
            sb_q.push_back(e);
            fin = 1;
         end
         @(posedge clk_i); #1;
         k++;
      end
      ch_valid_i = '0; ch_data_i = '0;
      if (!fin) check("model_bound", 32'd1, 32'd0);
      check("valid_up", {31'd0, eoc_valid_o}, 32'd1);
      check("busy_fall", {31'd0, busy_o}, 32'd0);
      h = $urandom_range(0, 5);
      repeat (h) begin
         start_i = 1'($urandom_range(0, 1));
         @(posedge clk_i); #1;
         check("hold_valid", {31'd0, eoc_valid_o}, 32'd1);
         check("hold_exit", exit_code_o, e.exit_code);
         check("hold_tmo", {31'd0, timeout_o}, {31'd0, e.tmo});
      end
      start_i = 1'($urandom_range(0, 1));
      eoc_ready_i = 1;
      @(posedge clk_i); #1;
      eoc_ready_i = 0; start_i = 0;
      check("valid_drop", {31'd0, eoc_valid_o}, 32'd0);
      check("no_restart", {31'd0, busy_o}, 32'd0);
      check("ch_done", {28'd0, ch_done_o}, {28'd0, m_done & mask});
   endtask

   task automatic rand_sched();
      clear_sched();
      slen = $urandom_range(2, 40);
      for (int k = 0; k < slen - 1; k++) begin
         sv[k] = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            sd[k][i][0]    = 1'($urandom_range(0, 1));
            sd[k][i][31:1] = ($urandom_range(0, 3) == 0) ? 31'($urandom_range(1, 200)) : 31'd0;
         end
      end
      sv[slen-1] = 4'hF;
      for (int i = 0; i < 4; i++) sd[slen-1][i] = 32'd1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      cfg_mask_i = '0; cfg_timeout_i = '0;
      rst_i = 1;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_valid", {31'd0, eoc_valid_o}, 32'd0);
      check("rst_exit", exit_code_o, 32'd0);
      check("rst_done", {28'd0, ch_done_o}, 32'd0);
      rst_i = 0;
      @(posedge clk_i); #1;

      // all pass, successive writes
      clear_sched();
      for (int i = 0; i < 4; i++) sched_wr(i, i, 32'h1);
      run(4'hF, 32'd0);
      // simultaneous fail, channel 0 never reports
      clear_sched();
      sched_wr(0, 2, 32'h7); sched_wr(0, 1, 32'h5);
      run(4'b0111, 32'd0);
      // timeout with only channel 0
      clear_sched();
      sched_wr(0, 0, 32'h1);
      run(4'b0011, 32'd10);
      // completion on the timeout cycle beats the timeout
      clear_sched();
      sched_wr(0, 0, 32'h1); sched_wr(9, 1, 32'h1);
      run(4'b0011, 32'd10);
      // filtering: disabled channel, done bit clear, repeat write
      clear_sched();
      sched_wr(0, 3, 32'h3); sched_wr(1, 0, 32'h4); sched_wr(2, 0, 32'h1);
      sched_wr(3, 0, 32'h9); sched_wr(4, 1, 32'h1);
      run(4'b0011, 32'd0);
      // empty mask
      clear_sched();
      run(4'b0000, 32'd5);

      for (int r = 0; r < 40; r++) begin
         rand_sched();
         run(4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 40)));
      end

      // abort mid-run
      start_i = 1; cfg_mask_i = 4'hF; cfg_timeout_i = 32'd0;
      @(posedge clk_i); #1;
      start_i = 0; ch_valid_i = 4'b0001; ch_data_i = 128'h1;
      @(posedge clk_i); #1;
      ch_valid_i = '0; ch_data_i = '0; abort_i = 1;
      @(posedge clk_i); #1;
      abort_i = 0;
      check("abort_busy", {31'd0, busy_o}, 32'd0);
      check("abort_done", {28'd0, ch_done_o}, 32'd1);
      repeat (3) begin
         @(posedge clk_i); #1;
         check("abort_novalid", {31'd0, eoc_valid_o}, 32'd0);
      end

      // reset during ARMED
      start_i = 1; cfg_mask_i = 4'hF; cfg_timeout_i = 32'd0;
      @(posedge clk_i); #1;
      start_i = 0; ch_valid_i = 4'b0010; ch_data_i = 128'h1 << 32;
      @(posedge clk_i); #1;
      ch_valid_i = '0; ch_data_i = '0; rst_i = 1;
      @(posedge clk_i); #1;
      rst_i = 0;
      check("mrst_busy", {31'd0, busy_o}, 32'd0);
      check("mrst_valid", {31'd0, eoc_valid_o}, 32'd0);
      check("mrst_done", {28'd0, ch_done_o}, 32'd0);
      check("mrst_exit", exit_code_o, 32'd0);
      check("mrst_tmo", {31'd0, timeout_o}, 32'd0);

      clear_sched();
      sched_wr(0, 1, 32'h21); sched_wr(0, 0, 32'h1);
      run(4'b0011, 32'd0);

      repeat (3) @(posedge clk_i);
      #1;
      check("sb_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
